// File: rtl/spi_minion_pushpull.sv
// SPI mode-0 minion: oversampled SPI pins, each received frame is pushed out on a val/rdy
// send port, and a single-entry transmit buffer fed by a val/rdy recv port supplies MISO.
module spi_minion_pushpull #(
  parameter int unsigned nbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic [nbits-1:0] recv_msg,
  input  logic             recv_val,
  output logic             recv_rdy,
  output logic [nbits-1:0] send_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic             overflow,
  output logic             frame_err
);

  localparam int unsigned cnt_w = $clog2(nbits + 2);
  localparam logic [cnt_w-1:0] cnt_full = cnt_w'(nbits);
  localparam logic [cnt_w-1:0] cnt_sat  = cnt_w'(nbits + 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_t;

  logic [2:0] cs_sync, sclk_sync, mosi_sync;
  logic       cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic [1:0] settle;
  logic       armed;

  // Bits [1:0] are the synchronizer, bit [2] is the edge-detect history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync   <= 3'b111;
      sclk_sync <= 3'b000;
      mosi_sync <= 3'b000;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      settle    <= 2'd0;
      armed     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[1:0], cs};
      sclk_sync <= {sclk_sync[1:0], sclk};
      mosi_sync <= {mosi_sync[1:0], mosi};
      cs_fall   <= cs_sync[2] & ~cs_sync[1];
      cs_rise   <= ~cs_sync[2] & cs_sync[1];
      sclk_rise <= ~sclk_sync[2] & sclk_sync[1];
      sclk_fall <= sclk_sync[2] & ~sclk_sync[1];
      // Only arm once a genuinely high cs has been seen after the reset values have
      // flushed, so a frame already in progress at reset release is ignored.
      if (settle != 2'd3) begin
        settle <= settle + 2'd1;
      end else if (cs_sync[1]) begin
        armed <= 1'b1;
      end
    end
  end

  state_t           state;
  logic             tx_valid;
  logic [nbits-1:0] tx_data;
  logic [nbits-1:0] shreg;
  logic [cnt_w-1:0] count;
  logic             accept;
  logic             load_ok;

  assign recv_rdy = ~tx_valid;
  assign accept   = recv_val & ~tx_valid;
  assign load_ok  = ~send_val | send_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      shreg     <= '0;
      count     <= '0;
      miso      <= 1'b0;
      send_msg  <= '0;
      send_val  <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      if (send_val && send_rdy) begin
        send_val <= 1'b0;
      end
      if (accept) begin
        tx_valid <= 1'b1;
        tx_data  <= recv_msg;
      end
      unique case (state)
        StIdle: begin
          if (cs_fall && armed) begin
            shreg    <= tx_valid ? tx_data : '0;
            miso     <= tx_valid & tx_data[nbits-1];
            // A word accepted in this same cycle waits for the next frame.
            tx_valid <= accept;
            count    <= '0;
            state    <= StShift;
          end
        end
        StShift: begin
          if (sclk_rise) begin
            shreg <= {shreg[nbits-2:0], mosi_sync[2]};
            if (count != cnt_sat) begin
              count <= count + cnt_w'(1);
            end
          end
          if (sclk_fall) begin
            miso <= shreg[nbits-1];
          end
          if (cs_rise) begin
            state <= StCommit;
          end
        end
        StCommit: begin
          state <= StIdle;
          if (count == cnt_full) begin
            if (load_ok) begin
              send_msg <= shreg;
              send_val <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_minion_pushpull.sv
// Randomised and directed bench for spi_minion_pushpull: a monitor checks every send transfer
// against a queue of expected words filled by a frame-level reference model.
module tb_spi_minion_pushpull;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cs = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic       miso;
  logic [7:0] recv_msg = 8'h00;
  logic       recv_val = 1'b0;
  logic       recv_rdy;
  logic [7:0] send_msg;
  logic       send_val;
  logic       send_rdy = 1'b0;
  logic       overflow, frame_err;

  spi_minion_pushpull #(.nbits(8)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int ovf_seen = 0, ferr_seen = 0;
  int exp_ovf = 0, exp_ferr = 0;
  logic [7:0] exp_q[$];
  bit         mtx_valid = 0;
  logic [7:0] mtx_word = 8'h00;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: samples on the falling clock edge, away from input changes.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (overflow) ovf_seen++;
        if (frame_err) ferr_seen++;
        if (send_val && send_rdy) begin
          if (exp_q.size() == 0) begin
            check("send_unexpected", {24'h0, send_msg}, 32'hffff_ffff);
          end else begin
            check("send_msg", {24'h0, send_msg}, {24'h0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic push_word(input logic [7:0] w);
    check("recv_rdy_before_push", {31'h0, recv_rdy}, 32'd1);
    @(posedge clk); #1 recv_val = 1'b1; recv_msg = w;
    @(posedge clk); #1 recv_val = 1'b0;
    mtx_valid = 1;
    mtx_word  = w;
  endtask

  task automatic run_frame(input logic [7:0] data, input int nclk, input bit check_lat,
                           input bit rdy_pulse, input bit push_at_fall, input logic [7:0] pw,
                           output logic [7:0] got);
    got = 8'h00;
    @(posedge clk); #1 cs = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 3 && push_at_fall) begin
        recv_val = 1'b1;
        recv_msg = pw;
      end
      if (k == 4) recv_val = 1'b0;
    end
    for (int i = 0; i < nclk; i++) begin
      mosi = (i < 8) ? data[7-i] : 1'($urandom_range(0, 1));
      repeat (8) @(posedge clk);
      #1;
      if (i < 8) got[7-i] = miso;
      sclk = 1'b1;
      repeat (8) @(posedge clk);
      #1 sclk = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1 cs = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin
        if (check_lat) check("latency_early", {31'h0, send_val}, 32'd0);
        if (rdy_pulse) send_rdy = 1'b1;
      end
      if (k == 5) begin
        if (check_lat) check("latency_5", {31'h0, send_val}, 32'd1);
        if (rdy_pulse) begin
          send_rdy = 1'b0;
          check("same_cycle_val", {31'h0, send_val}, 32'd1);
          check("same_cycle_msg", {24'h0, send_msg}, {24'h0, data});
        end
      end
    end
    repeat (10) @(posedge clk);
  endtask

  // Reference model at frame level: what MISO carries and what the frame yields.
  task automatic model_frame(input logic [7:0] data, input int nclk, input bit check_lat,
                             input bit rdy_pulse, input bit push_at_fall,
                             input logic [7:0] pw);
    logic [7:0] exp_miso, got, mask;
    bit occupied;
    exp_miso  = mtx_valid ? mtx_word : 8'h00;
    mtx_valid = 0;
    occupied  = (exp_q.size() > 0) && !send_rdy && !rdy_pulse;
    if (nclk == 8) begin
      if (occupied) exp_ovf++;
      else exp_q.push_back(data);
    end else begin
      exp_ferr++;
    end
    run_frame(data, nclk, check_lat, rdy_pulse, push_at_fall, pw, got);
    if (push_at_fall) begin
      mtx_valid = 1;
      mtx_word  = pw;
    end
    mask = (nclk >= 8) ? 8'hff : 8'(8'hff << (8 - nclk));
    check("miso_bits", {24'h0, got & mask}, {24'h0, exp_miso & mask});
    check("overflow_count", ovf_seen, exp_ovf);
    check("frame_err_count", ferr_seen, exp_ferr);
    check("recv_rdy_after", {31'h0, recv_rdy}, {31'h0, !mtx_valid});
  endtask

  initial begin
    int waited;
    repeat (3) @(posedge clk);
    #1;
    check("rst_miso", {31'h0, miso}, 32'd0);
    check("rst_send_val", {31'h0, send_val}, 32'd0);
    check("rst_send_msg", {24'h0, send_msg}, 32'd0);
    check("rst_overflow", {31'h0, overflow}, 32'd0);
    check("rst_frame_err", {31'h0, frame_err}, 32'd0);
    check("rst_recv_rdy", {31'h0, recv_rdy}, 32'd1);
    reset = 1'b1;
    repeat (10) @(posedge clk);

    // Basic loopback with exact send latency.
    #1 send_rdy = 1'b1;
    push_word(8'hA5);
    model_frame(8'h3C, 8, 1, 0, 0, 8'h00);
    // Empty transmit buffer.
    model_frame(8'h96, 8, 0, 0, 0, 8'h00);

    // Overflow with the core stalled.
    @(posedge clk); #1 send_rdy = 1'b0;
    model_frame(8'h11, 8, 0, 0, 0, 8'h00);
    model_frame(8'h22, 8, 0, 0, 0, 8'h00);
    check("ovf_hold_msg", {24'h0, send_msg}, 32'h11);
    check("ovf_hold_val", {31'h0, send_val}, 32'd1);
    @(posedge clk); #1 send_rdy = 1'b1;
    repeat (4) @(posedge clk);

    // Short and long frames.
    model_frame(8'h5B, 7, 0, 0, 0, 8'h00);
    model_frame(8'hC6, 9, 0, 0, 0, 8'h00);

    // Transfer and load in the same COMMIT cycle.
    @(posedge clk); #1 send_rdy = 1'b0;
    model_frame(8'h77, 8, 0, 0, 0, 8'h00);
    model_frame(8'h88, 8, 0, 1, 0, 8'h00);
    @(posedge clk); #1 send_rdy = 1'b1;
    repeat (4) @(posedge clk);

    // recv word coincident with cs_fall goes out on the following frame.
    model_frame(8'h42, 8, 0, 0, 1, 8'hC3);
    model_frame(8'h24, 8, 0, 0, 0, 8'h00);

    // Reset in the middle of a frame, released with cs still low.
    @(posedge clk); #1 cs = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        mtx_valid = 0;
      end
      #1 mosi = 1'($urandom_range(0, 1));
      repeat (8) @(posedge clk);
      #1 sclk = 1'b1;
      repeat (8) @(posedge clk);
      #1 sclk = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1 cs = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("rst_frame_no_val", {31'h0, send_val}, 32'd0);
    check("rst_frame_no_err", ferr_seen, exp_ferr);
    model_frame(8'h5A, 8, 0, 0, 0, 8'h00);

    // Randomised traffic.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      int nc;
      @(posedge clk); #1 send_rdy = ($urandom_range(0, 3) != 0);
      repeat (2) @(posedge clk);
      if (!mtx_valid && $urandom_range(0, 1) == 1) push_word(8'($urandom));
      d  = 8'($urandom);
      nc = $urandom_range(0, 4);
      nc = (nc == 0) ? 7 : (nc == 4) ? 9 : 8;
      model_frame(d, nc, 0, 0, 0, 8'h00);
    end

    @(posedge clk); #1 send_rdy = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    check("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_minion_pushpull.md
# spi_minion_pushpull

SPI peripheral (minion) endpoint that sits directly downstream of the SPI master: it consumes `cs`, `sclk` and `mosi` and returns `miso`. Each frame is converted into val/rdy traffic for the local core:

- Each complete `nbits` frame shifted in on MOSI is presented on a send (push) interface.
- Each word the core hands in on a recv (pull) interface is shifted out on MISO during the next frame.

All SPI inputs are asynchronous to `clk` and are oversampled.

## Interface

Clocking and reset:

- One clock. Reset is asynchronous and active-low.

Parameters:

- `nbits`, default 8: SPI frame and message width in bits.

Ports:

- `clk` in, 1: system clock; all state is updated on its rising edge.
- `reset` in, 1: asynchronous, active-low reset.
- `cs` in, 1: SPI chip select, active-low, asynchronous to `clk`.
- `sclk` in, 1: SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous.
- `mosi` in, 1: serial data from the master, MSB first.
- `miso` out, 1: serial data to the master, MSB first.
- `recv_msg` in, `nbits`: word to transmit on the next frame.
- `recv_val` in, 1: `recv_msg` is valid.
- `recv_rdy` out, 1: the transmit buffer is empty.
- `send_msg` out, `nbits`: received frame.
- `send_val` out, 1: `send_msg` is valid.
- `send_rdy` in, 1: the core accepts `send_msg`.
- `overflow` out, 1: one-cycle pulse when a completed frame is dropped.
- `frame_err` out, 1: one-cycle pulse when a frame ends with a bit count other than `nbits`.

## Operation

Input synchronization and edge detection:

- `cs`, `sclk` and `mosi` each pass through a 2-flop synchronizer.
- A third register per signal provides edge detection: `cs_fall`, `cs_rise`, `sclk_rise`, `sclk_fall`.
- The synchronizer flops reset to `cs`=1, `sclk`=0 and `mosi`=0.

Transmit buffer:

- One entry plus a valid bit.
- `recv_rdy` = !tx_valid.
- A word is accepted when `recv_val && recv_rdy`.

State machine (states IDLE, SHIFT, COMMIT; reset state IDLE):

- **IDLE**
  - On `cs_fall`:
    - Load the shift register from the transmit buffer if tx_valid, otherwise all zeros.
    - Clear tx_valid.
    - Clear the bit counter.
    - Go to SHIFT.
  - A word accepted on the same cycle as `cs_fall` is not used for this frame; it stays buffered for the next frame.
- **SHIFT**
  - On `sclk_rise`:
    - Shift the synchronized `mosi` into the LSB of the shift register.
    - Increment the bit counter, saturating at `nbits`+1.
  - On `sclk_fall`: advance the MISO bit (`miso` = next MSB).
  - On `cs_rise`: go to COMMIT.
- **COMMIT** (one cycle), then go to IDLE:
  - If count == `nbits` and the output slot is free (`!send_val`, or `send_rdy` this cycle): load `send_msg` with the shift register and set `send_val`.
  - If count == `nbits` and the slot is still occupied: drop the frame, keep the old `send_msg`, pulse `overflow`.
  - If count != `nbits`: drop the frame and pulse `frame_err`.

Send handshake:

- `send_val` stays high until `send_rdy`.
- `send_msg` is stable while `send_val` is high.
- A transfer and a new load in the same COMMIT cycle are both honoured: the old word transfers, the new word loads.

MISO output:

- `miso` is driven from the shift-register MSB.
- The counter has width clog2(`nbits`+2).

## Timing

Reset values:

- `miso`=0, `send_val`=0, `send_msg`=0, `overflow`=0, `frame_err`=0.
- tx_valid=0, so `recv_rdy`=1 while reset is asserted and after it is released.

Latencies:

- Pin edge to internal edge pulse: 3 `clk` cycles.
- `cs` rising at the pin to `send_val` high: 5 cycles (3 for detection, 1 in COMMIT, `send_val` registered on the following edge).
- After the `cs_fall` detection cycle, `miso` holds the first bit until the first `sclk_fall`.

Frequency requirement:

- `clk` ≥ 8× `sclk`.
- The master must hold `cs` low for ≥4 `clk` cycles before the first `sclk` rising edge.

Boundary conditions:

- **Async reset mid-frame:** all state is cleared. Because IDLE acts only on `cs_fall`, a frame already in progress when reset releases (`cs` low) is ignored until `cs` goes high and falls again.
- **`sclk` edges while in IDLE:** ignored.
- **More than `nbits` clocks in a frame:** the counter saturates and the frame produces `frame_err`.

## Test plan

- **Basic loopback.** After reset, push `recv_msg`=0xA5. Master sends 0x3C with 8 clocks. Expect:
  - MISO bits equal 1,0,1,0,0,1,0,1.
  - `send_msg`=0x3C with `send_val` high 5 cycles after `cs` rises.
  - `recv_rdy` returns high after `cs_fall`.
- **Empty transmit buffer.** Run a frame with no word pushed. Expect MISO all zeros and the received word delivered normally.
- **Overflow.** Hold `send_rdy`=0. Run frames 0x11 then 0x22. Expect:
  - `send_msg` stays 0x11.
  - `overflow` pulses once in the second frame's COMMIT cycle.
  - Raising `send_rdy` transfers 0x11.
- **Short and long frames.** Run a 7-clock frame and a 9-clock frame. Expect `frame_err` to pulse once for each, with no `send_val`.
- **Simultaneous events.**
  - `send_rdy` high during a COMMIT with `send_val` pending: expect the old word to transfer and the new word to load in the same cycle.
  - `recv_val` coincident with `cs_fall`: expect that word to be sent on the following frame, not the current one.
- **Reset mid-frame.** Assert `reset` after 4 `sclk` edges and release it with `cs` still low. Expect:
  - No `send_val` and no `frame_err` for that frame.
  - The next full frame 0x5A is received correctly.
